// File: rtl/oled_cmd_sequencer.sv
// oled_cmd_sequencer: queues OLED display requests and issues them one at a
// time over the interface's mode/start/ready handshake.
// Tracks display power state, drops illegal requests with a reject pulse and
// latches a sticky timeout when the interface stalls.
// Optional build macro: AUTO_POWERON_EN preloads a turnon request at reset.
module oled_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int ACK_TIMEOUT  = 256,
  parameter int DONE_TIMEOUT = 16000000
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  input  logic                   i_REQ_VALID,
  input  logic [1:0]             i_REQ_MODE,
  output logic                   o_REQ_READY,
  input  logic                   i_READY,
  output logic [1:0]             o_MODE,
  output logic                   o_START,
  output logic                   o_BUSY,
  output logic                   o_DISPLAY_ON,
  output logic                   o_REJECT,
  output logic                   o_TIMEOUT,
  output logic [$clog2(DEPTH):0] o_FIFO_COUNT
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [1:0] M_ON = 2'b00, M_OFF = 2'b01;

`ifdef AUTO_POWERON_EN
  // mem[0] resets to 00 (turnon), so one queued entry is a turnon request
  localparam logic [AW:0]   CNT_RST = (AW+1)'(1);
  localparam logic [AW-1:0] WR_RST  = AW'(1);
`else
  localparam logic [AW:0]   CNT_RST = '0;
  localparam logic [AW-1:0] WR_RST  = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_ERROR} state_t;

  state_t          state_q, state_d;
  logic            rdy_m, rdy_s;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_q;
  logic            push, pop;
  logic [1:0]      mode_q, mode_d;
  logic            start_q, start_d, disp_q, disp_d;
  logic            reject_q, reject_d, timeout_q, timeout_d;
  logic [TW-1:0]   timer_q, timer_d;
  // popped entry waiting one cycle for validation
  logic            pend_vld_q;
  logic [1:0]      pend_mode_q;
  logic            legal;

  assign o_REQ_READY  = (count_q < (AW+1)'(DEPTH)) && (state_q != S_ERROR);
  assign push         = i_REQ_VALID && o_REQ_READY;
  assign pop          = (state_q == S_IDLE) && (count_q != '0) && rdy_s && !pend_vld_q;
  assign o_MODE       = mode_q;
  assign o_START      = start_q;
  assign o_DISPLAY_ON = disp_q;
  assign o_REJECT     = reject_q;
  assign o_TIMEOUT    = timeout_q;
  assign o_FIFO_COUNT = count_q;
  assign o_BUSY       = (state_q != S_IDLE) || (count_q != '0) || pend_vld_q;

  // two-flop synchronizer for the interface ready
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= i_READY;
      rdy_s <= rdy_m;
    end
  end

  // request FIFO; error state discards everything queued
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= WR_RST;
      rd_ptr      <= '0;
      count_q     <= CNT_RST;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_REQ_MODE;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      pend_vld_q <= pop;
      if (pop) pend_mode_q <= mem[rd_ptr];
      if (state_q == S_ERROR) begin
        rd_ptr  <= wr_ptr;
        count_q <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // sequencer state register
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      start_q   <= 1'b0;
      disp_q    <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      disp_q    <= disp_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  // legality of the pending request against the current power state
  always_comb begin
    legal = 1'b0;
    case (pend_mode_q)
      M_ON:    legal = !disp_q;
      default: legal = disp_q;
    endcase
  end

  // next-state and handshake control
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    start_d   = 1'b0;
    disp_d    = disp_q;
    reject_d  = 1'b0;
    timeout_d = timeout_q;
    timer_d   = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          if (legal) begin
            mode_d  = pend_mode_q;
            start_d = 1'b1;
            timer_d = '0;
            state_d = S_ISSUE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        if (!rdy_s) begin
          start_d = 1'b0;
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else if (timer_q == ACK_LAST) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_WAIT_DONE: begin
        if (rdy_s) begin
          if (mode_q == M_ON)  disp_d = 1'b1;
          if (mode_q == M_OFF) disp_d = 1'b0;
          state_d = S_IDLE;
        end else if (timer_q == DONE_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      default: begin
        timeout_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// tb_oled_cmd_sequencer: table of request/expected-outcome records plus
// hand-written sequences for FIFO full, ack timeout and async reset.
module tb_oled_cmd_sequencer;
  logic       i_CLK = 1'b0, i_RST_N = 1'b0, i_REQ_VALID = 1'b0, i_READY = 1'b0;
  logic [1:0] i_REQ_MODE = '0;
  logic       o_REQ_READY, o_START, o_BUSY, o_DISPLAY_ON, o_REJECT, o_TIMEOUT;
  logic [1:0] o_MODE;
  logic [2:0] o_FIFO_COUNT;
  int n_chk = 0, n_fail = 0;

  oled_cmd_sequencer #(.DEPTH(4), .ACK_TIMEOUT(256), .DONE_TIMEOUT(16000000)) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_REQ_VALID(i_REQ_VALID), .i_REQ_MODE(i_REQ_MODE),
    .o_REQ_READY(o_REQ_READY), .i_READY(i_READY), .o_MODE(o_MODE), .o_START(o_START),
    .o_BUSY(o_BUSY), .o_DISPLAY_ON(o_DISPLAY_ON), .o_REJECT(o_REJECT),
    .o_TIMEOUT(o_TIMEOUT), .o_FIFO_COUNT(o_FIFO_COUNT));

  always #5 i_CLK = ~i_CLK;

  typedef struct { logic [1:0] mode; logic exp_reject; logic exp_disp; } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK); #1;
  endtask

  task automatic push(input logic [1:0] m);
    i_REQ_VALID = 1'b1; i_REQ_MODE = m;
    tick();
    i_REQ_VALID = 1'b0;
  endtask

  task automatic wait_start(input logic v, input int bound, input string name);
    int n = 0;
    while (o_START !== v && n < bound) begin tick(); n++; end
    chk(name, o_START, v);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (o_BUSY !== 1'b0 && n < bound) begin tick(); n++; end
    chk(name, o_BUSY, 0);
  endtask

  // interface model: acknowledge a start, then complete the command
  task automatic serve(input logic [1:0] m);
    wait_start(1'b1, 30, "serve_start_rise");
    chk("serve_mode", o_MODE, m);
    repeat (3) tick();
    i_READY = 1'b0;
    wait_start(1'b0, 10, "serve_start_drop");
    repeat (3) tick();
    i_READY = 1'b1;
  endtask

  task automatic rst_seq(input logic rdy);
    i_RST_N = 1'b0; i_REQ_VALID = 1'b0; i_READY = rdy;
    repeat (2) tick();
    i_RST_N = 1'b1;
    repeat (3) tick();
  endtask

  // push one request and check reject/issue timing and final power state
  task automatic do_req(input vec_t v);
    int first_rej = 0, first_start = 0, rej_cnt = 0;
    push(v.mode);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (o_REJECT) begin rej_cnt++; if (first_rej == 0) first_rej = n; end
      if (o_START && first_start == 0) first_start = n;
    end
    if (v.exp_reject) begin
      chk("rej_latency", first_rej, 2);
      chk("rej_width", rej_cnt, 1);
      chk("rej_no_start", first_start, 0);
      wait_idle(10, "rej_idle");
    end else begin
      chk("start_latency", first_start, 2);
      chk("no_reject", rej_cnt, 0);
      chk("issue_mode", o_MODE, v.mode);
      repeat (32) tick();
      chk("start_held", o_START, 1);
      i_READY = 1'b0;
      wait_start(1'b0, 10, "ack_drop");
      repeat (5) tick();
      i_READY = 1'b1;
      wait_idle(10, "done_idle");
    end
    chk("display_on", o_DISPLAY_ON, v.exp_disp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [1:0] fmodes[4];
    vecs[0] = '{2'b10, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 1'b0, 1'b1};
    vecs[3] = '{2'b00, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 1'b0, 1'b1};
    vecs[5] = '{2'b11, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 1'b1, 1'b0};
    fmodes[0] = 2'b00; fmodes[1] = 2'b10; fmodes[2] = 2'b11; fmodes[3] = 2'b01;

    i_READY = 1'b1;
    repeat (2) tick();
`ifdef AUTO_POWERON_EN
    chk("auto_rst_count", o_FIFO_COUNT, 1);
    i_RST_N = 1'b1;
    wait_start(1'b1, 10, "auto_start");
    chk("auto_mode", o_MODE, 0);
    i_READY = 1'b0;
    wait_start(1'b0, 10, "auto_ack");
    repeat (3) tick();
    i_READY = 1'b1;
    wait_idle(10, "auto_idle");
    chk("auto_disp", o_DISPLAY_ON, 1);
    do_req(vecs[3]);
`else
    chk("rst_start", o_START, 0);
    chk("rst_mode", o_MODE, 0);
    chk("rst_disp", o_DISPLAY_ON, 0);
    chk("rst_reject", o_REJECT, 0);
    chk("rst_timeout", o_TIMEOUT, 0);
    chk("rst_count", o_FIFO_COUNT, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_req_ready", o_REQ_READY, 1);
    i_RST_N = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) do_req(vecs[i]);

    // FIFO full with the interface stalled, then drained in order
    i_READY = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      push(fmodes[i]);
      chk("full_count", o_FIFO_COUNT, i + 1);
      chk("full_req_ready", o_REQ_READY, (i < 3) ? 1 : 0);
    end
    chk("full_no_start", o_START, 0);
    push(2'b00);
    chk("full_5th_dropped", o_FIFO_COUNT, 4);
    i_READY = 1'b1;
    for (int i = 0; i < 4; i++) serve(fmodes[i]);
    wait_idle(20, "drain_idle");
    chk("drain_disp", o_DISPLAY_ON, 0);
    chk("drain_count", o_FIFO_COUNT, 0);

    // ack timeout: ready never drops
    rst_seq(1'b1);
    push(2'b00);
    tick(); tick();
    chk("to_start", o_START, 1);
    repeat (255) tick();
    chk("to_not_yet", o_TIMEOUT, 0);
    chk("to_start_held", o_START, 1);
    tick();
    chk("to_flag", o_TIMEOUT, 1);
    chk("to_start_low", o_START, 0);
    chk("to_req_ready", o_REQ_READY, 0);
    repeat (20) tick();
    push(2'b10);
    chk("to_sticky", o_TIMEOUT, 1);
    chk("to_count", o_FIFO_COUNT, 0);
    chk("to_busy", o_BUSY, 1);
    i_RST_N = 1'b0;
    #1;
    chk("to_rst_clear", o_TIMEOUT, 0);

    // asynchronous reset while waiting for completion with entries queued
    rst_seq(1'b1);
    push(2'b00);
    serve(2'b00);
    wait_idle(20, "mid_on_idle");
    chk("mid_disp_on", o_DISPLAY_ON, 1);
    push(2'b10);
    wait_start(1'b1, 10, "mid_start");
    chk("mid_mode", o_MODE, 2'b10);
    i_READY = 1'b0;
    wait_start(1'b0, 10, "mid_ack");
    push(2'b11);
    push(2'b01);
    chk("mid_count", o_FIFO_COUNT, 2);
    #3;
    i_RST_N = 1'b0;
    #1;
    chk("mid_rst_start", o_START, 0);
    chk("mid_rst_mode", o_MODE, 0);
    chk("mid_rst_disp", o_DISPLAY_ON, 0);
    chk("mid_rst_count", o_FIFO_COUNT, 0);
    chk("mid_rst_busy", o_BUSY, 0);
    chk("mid_rst_timeout", o_TIMEOUT, 0);
    chk("mid_rst_req_ready", o_REQ_READY, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oled_cmd_sequencer.md
Name: oled_cmd_sequencer

Overview:
- Upstream request scheduler for the OLED interface. Accepts display requests (turnon, turnoff, ascii, shape) from application logic and queues them in a small FIFO.
- Issues each request to the interface via its mode/start/ready handshake, so requests arriving while the interface is busy are not lost.
- Tracks display power state, rejects illegal requests, and flags a stalled interface with a timeout.
- Runs on the 100 MHz system clock. The interface runs on its divided serial clock, so all handshake signals are treated as crossing clock domains.

Parameters:
- DEPTH, 4, request FIFO depth; must be a power of two, minimum 2.
- ACK_TIMEOUT, 256, i_CLK cycles allowed between o_START rising and synchronized i_READY falling.
- DONE_TIMEOUT, 16000000, i_CLK cycles allowed between ack and synchronized i_READY rising (covers the 100 ms turnon wait).

Ports:
- i_CLK  input  1  system clock, 100 MHz.
- i_RST_N  input  1  asynchronous, active-low reset.
- i_REQ_VALID  input  1  request present.
- i_REQ_MODE  input  2  request code: 00 turnon, 01 turnoff, 10 ascii, 11 shape.
- o_REQ_READY  output  1  FIFO can accept a request this cycle.
- i_READY  input  1  ready from the OLED interface; asynchronous to i_CLK.
- o_MODE  output  2  mode to the interface.
- o_START  output  1  start to the interface; level, held until acknowledged.
- o_BUSY  output  1  high in any state other than S_IDLE, or when the FIFO is non-empty.
- o_DISPLAY_ON  output  1  display power state.
- o_REJECT  output  1  one-cycle pulse when a dequeued request is dropped as illegal.
- o_TIMEOUT  output  1  sticky error flag.
- o_FIFO_COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low, applied to every register.
- Reset values: o_MODE=00, o_START=0, o_DISPLAY_ON=0, o_REJECT=0, o_TIMEOUT=0, o_FIFO_COUNT=0, FIFO pointers=0, state=S_IDLE, both synchronizer stages=0.
- Reset mid-handshake drops o_START immediately and empties the FIFO.
- i_READY passes through a 2-flop synchronizer; rdy_s is the second stage. All decisions use rdy_s.
- FIFO push: i_REQ_VALID && o_REQ_READY.
- o_REQ_READY = (count < DEPTH) && state != S_ERROR. It is derived from registered count only, so no push occurs when full even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: count unchanged, data order preserved.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- S_IDLE:
  - Pop occurs only when the FIFO is non-empty and rdy_s=1.
  - Validate the popped mode:
    - turnon while o_DISPLAY_ON=1: illegal.
    - turnoff while o_DISPLAY_ON=0: illegal.
    - ascii or shape while o_DISPLAY_ON=0: illegal.
  - Illegal request: o_REJECT pulses next cycle, stay in S_IDLE. The next pop may occur in the following cycle.
  - Legal request: latch o_MODE, set o_START=1 on the next edge, clear the timer, go to S_ISSUE.
- S_ISSUE:
  - Hold o_START and o_MODE; timer counts up.
  - On rdy_s=0 (interface acknowledged): o_START=0, clear the timer, go to S_WAIT_DONE.
  - If the timer reaches ACK_TIMEOUT-1: go to S_ERROR.
- S_WAIT_DONE:
  - o_START=0; timer counts up.
  - On rdy_s=1: apply the completed mode (turnon sets o_DISPLAY_ON, turnoff clears it; ascii and shape leave it unchanged), then go to S_IDLE.
  - If the timer reaches DONE_TIMEOUT-1: go to S_ERROR.
- S_ERROR:
  - o_START=0, o_TIMEOUT=1, FIFO contents discarded (count forced to 0), o_REQ_READY=0.
  - Exit only by reset.
- Timer width is $clog2(max(ACK_TIMEOUT, DONE_TIMEOUT)); it saturates and never wraps.
- Latency: a request pushed at edge t into an empty FIFO, with state S_IDLE and rdy_s=1, gives pop at t+1 and o_START high after edge t+2.
- o_MODE stays stable from o_START rising until the next legal pop.

Optional Feature:
- Macro AUTO_POWERON_EN.
- Defined: when reset deasserts, a turnon request is preloaded so that o_FIFO_COUNT=1 in the first cycle. The display powers up with no user request. A user turnon queued behind it is then rejected as illegal.
- Undefined: the FIFO is empty after reset, and nothing is issued until a request is pushed.

Test Plan:
- Turnon: reset, drive i_READY=1, push mode 00 -> o_START=1 with o_MODE=00; model drops i_READY 40 cycles later -> o_START=0; raise i_READY later -> o_DISPLAY_ON=1, o_BUSY=0.
- Illegal requests: from reset with display off, push 10 -> o_REJECT single-cycle pulse, o_START stays 0. After turnon completes, push 00 -> o_REJECT pulse.
- FIFO full: hold i_READY=0, push 5 requests with DEPTH=4 -> o_REQ_READY=0 after the 4th push, 5th not accepted, o_FIFO_COUNT=4. Release i_READY -> requests issued in push order 00,10,11,01 and o_DISPLAY_ON ends at 0.
- Ack timeout: push 00, never lower i_READY -> after 256 cycles o_TIMEOUT=1, o_START=0, o_REQ_READY=0; state holds until i_RST_N pulses low.
- Reset mid-handshake: assert i_RST_N=0 while in S_WAIT_DONE with 2 entries queued -> all outputs return to reset values asynchronously, o_FIFO_COUNT=0.
- AUTO_POWERON_EN defined: release reset with i_READY=1 -> o_START rises with o_MODE=00 without any push.
